// File: rtl/banked_registers.sv
// Register file with NUM_BANKS copies of a banked low region plus a shared
// region holding read-only taps, a self-clearing trigger and the bank select.
module banked_registers #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int BANK_REGS = 16,
  parameter int NUM_REGS  = 32,
  parameter int NUM_BANKS = 4,
  parameter int RO_BASE   = 28,
  parameter int RO_NUM    = 2,
  parameter int TRIG_ADDR = 27
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        w_enable,
  input  logic [ADDR_W-1:0]                           w_addr,
  input  logic [DATA_W-1:0]                           w_data,
  input  logic                                        hw_we,
  input  logic [ADDR_W-1:0]                           hw_addr,
  input  logic [DATA_W-1:0]                           hw_data,
  input  logic [ADDR_W-1:0]                           r_addr_a,
  input  logic [ADDR_W-1:0]                           r_addr_b,
  output logic [DATA_W-1:0]                           r_data_a,
  output logic [DATA_W-1:0]                           r_data_b,
  input  logic [RO_NUM*DATA_W-1:0]                    ro_data,
  output logic [(NUM_REGS-BANK_REGS)*DATA_W-1:0]      shared_q,
  output logic [(NUM_BANKS>1 ? $clog2(NUM_BANKS) : 1)-1:0] bank_q,
  output logic [DATA_W-1:0]                           trig_pulse,
  output logic                                        err_pulse
);

  localparam int BANK_SEL_ADDR = NUM_REGS - 1;
  localparam int SH_N = NUM_REGS - BANK_REGS;
  localparam int BW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BRW  = (BANK_REGS > 1) ? $clog2(BANK_REGS) : 1;
  localparam int SHW  = (SH_N > 1) ? $clog2(SH_N) : 1;

  if (!(BANK_REGS < RO_BASE && RO_BASE + RO_NUM <= BANK_SEL_ADDR &&
        TRIG_ADDR >= BANK_REGS && TRIG_ADDR < NUM_REGS &&
        !(TRIG_ADDR >= RO_BASE && TRIG_ADDR < RO_BASE + RO_NUM) &&
        TRIG_ADDR != BANK_SEL_ADDR && NUM_BANKS >= 1 &&
        NUM_REGS <= (1 << ADDR_W))) begin : g_bad_cfg
    $error("banked_registers: illegal parameter combination");
  end

  logic [DATA_W-1:0]            bank_mem_q [NUM_BANKS][BANK_REGS];
  logic [SH_N-1:0][DATA_W-1:0]  sh_q;
  logic                         err_q;

  int unsigned wa, ha;
  logic sw_ro, sw_bank, sw_bsel, sw_ok, hw_ok, collide, err_d;

  assign wa = 32'(w_addr);
  assign ha = 32'(hw_addr);

  always_comb begin
    sw_ro   = (wa >= RO_BASE) && (wa < RO_BASE + RO_NUM);
    sw_bank = (wa < BANK_REGS);
    sw_bsel = (wa == BANK_SEL_ADDR);
    hw_ok   = hw_we && (ha >= BANK_REGS) && (ha < NUM_REGS) && (ha != BANK_SEL_ADDR) &&
              !((ha >= RO_BASE) && (ha < RO_BASE + RO_NUM));
    collide = w_enable && hw_ok && (wa == ha);
    // A bank-select write is only legal when it names an existing bank.
    sw_ok   = w_enable && (wa < NUM_REGS) && !sw_ro && !collide &&
              !(sw_bsel && (32'(w_data) >= NUM_BANKS));
    err_d   = (w_enable && !sw_ok) || (hw_we && !hw_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int r = 0; r < BANK_REGS; r++)
          bank_mem_q[b][r] <= '0;
      err_q <= 1'b0;
    end else begin
      if (sw_ok && sw_bank) bank_mem_q[bank_q][w_addr[BRW-1:0]] <= w_data;
      err_q <= err_d;
    end
  end

  for (genvar i = 0; i < SH_N; i++) begin : g_sh
    localparam int A = BANK_REGS + i;
    if (A >= RO_BASE && A < RO_BASE + RO_NUM) begin : g_ro
      assign sh_q[i] = ro_data[(A-RO_BASE)*DATA_W +: DATA_W];
    end else begin : g_rw
      logic [DATA_W-1:0] reg_q, reg_d;
      always_comb begin
        reg_d = (A == TRIG_ADDR) ? '0 : reg_q;
        if (hw_ok && ha == A)      reg_d = hw_data;
        else if (sw_ok && wa == A) reg_d = w_data;
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) reg_q <= '0;
        else      reg_q <= reg_d;
      end
      assign sh_q[i] = reg_q;
    end
  end

  assign bank_q     = sh_q[SH_N-1][BW-1:0];
  assign trig_pulse = sh_q[TRIG_ADDR-BANK_REGS];
  assign err_pulse  = err_q;
  assign shared_q   = sh_q;

  function automatic logic [DATA_W-1:0] rd_sel(input logic [ADDR_W-1:0] a);
    int unsigned ra;
    ra = 32'(a);
    rd_sel = '0;
    if (ra < BANK_REGS)     rd_sel = bank_mem_q[bank_q][a[BRW-1:0]];
    else if (ra < NUM_REGS) rd_sel = sh_q[SHW'(ra - BANK_REGS)];
  endfunction

  assign r_data_a = rd_sel(r_addr_a);
  assign r_data_b = rd_sel(r_addr_b);

endmodule

// File: tb/tb_banked_registers.sv
// Directed plus randomized checks of banked_registers against an array-based model.
module tb_banked_registers;

  localparam int DW = 8, AW = 6, BR = 16, NR = 32, NB = 4, ROB = 28, RON = 2, TRG = 27;
  localparam int BSEL = NR - 1;

  logic clk, rst;
  logic w_enable, hw_we;
  logic [AW-1:0] w_addr, hw_addr, r_addr_a, r_addr_b;
  logic [DW-1:0] w_data, hw_data, r_data_a, r_data_b, trig_pulse;
  logic [RON*DW-1:0] ro_data;
  logic [(NR-BR)*DW-1:0] shared_q;
  logic [1:0] bank_q;
  logic err_pulse;

  banked_registers dut (
    .clk(clk), .rst(rst),
    .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
    .hw_we(hw_we), .hw_addr(hw_addr), .hw_data(hw_data),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(r_data_a), .r_data_b(r_data_b),
    .ro_data(ro_data), .shared_q(shared_q), .bank_q(bank_q),
    .trig_pulse(trig_pulse), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;

  // Reference state: banks by [bank][addr], shared by absolute address.
  logic [7:0] mbank [NB][BR];
  logic [7:0] msh [NR];
  int   mbsel;
  logic merr;

  function automatic bit is_ro(int a);
    return a >= ROB && a < ROB + RON;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) for (int r = 0; r < BR; r++) mbank[b][r] = 8'h00;
    for (int a = 0; a < NR; a++) msh[a] = 8'h00;
    mbsel = 0;
    merr  = 1'b0;
  endtask

  function automatic logic [7:0] model_rd(int a);
    if (a < BR) return mbank[mbsel][a];
    if (is_ro(a)) return ro_data[(a-ROB)*8 +: 8];
    if (a >= NR) return 8'h00;
    return msh[a];
  endfunction

  task automatic model_edge(bit swe, int sa, int sd, bit hwe, int ha, int hd);
    bit hw_good;
    int old_bsel;
    old_bsel = mbsel;
    merr = 1'b0;
    msh[TRG] = 8'h00;
    hw_good = hwe && ha >= BR && ha < NR && !is_ro(ha) && ha != BSEL;
    if (hwe && !hw_good) merr = 1'b1;
    if (hw_good) msh[ha] = 8'(hd);
    if (swe) begin
      if (sa >= NR || is_ro(sa)) merr = 1'b1;
      else if (hw_good && ha == sa) merr = 1'b1;
      else if (sa < BR) mbank[old_bsel][sa] = 8'(sd);
      else if (sa == BSEL) begin
        if (sd < NB) begin mbsel = sd; msh[BSEL] = 8'(sd); end
        else merr = 1'b1;
      end
      else msh[sa] = 8'(sd);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [127:0] exp_sh;
    int ra, rb;
    exp_sh = '0;
    for (int i = 0; i < NR - BR; i++) exp_sh[i*8 +: 8] = model_rd(BR + i);
    chk({tag, ".err"},  128'(err_pulse),  128'(merr));
    chk({tag, ".bank"}, 128'(bank_q),     128'(mbsel));
    chk({tag, ".trig"}, 128'(trig_pulse), 128'(msh[TRG]));
    chk({tag, ".sh"},   128'(shared_q),   exp_sh);
    ra = int'($urandom_range(0, 63));
    rb = int'($urandom_range(0, 15));
    r_addr_a = 6'(ra);
    r_addr_b = 6'(rb);
    #1;
    chk({tag, ".rda"}, 128'(r_data_a), 128'(model_rd(ra)));
    chk({tag, ".rdb"}, 128'(r_data_b), 128'(model_rd(rb)));
  endtask

  task automatic step(input string tag, input bit swe, input int sa, input int sd,
                      input bit hwe, input int ha, input int hd);
    w_enable = swe; w_addr = 6'(sa); w_data = 8'(sd);
    hw_we = hwe; hw_addr = 6'(ha); hw_data = 8'(hd);
    @(posedge clk);
    model_edge(swe, sa & 63, sd & 255, hwe, ha & 63, hd & 255);
    #1;
    w_enable = 1'b0; hw_we = 1'b0;
    check_all(tag);
  endtask

  task automatic rd_a(input string tag, input int a, input logic [7:0] exp);
    r_addr_a = 6'(a);
    #1;
    chk(tag, 128'(r_data_a), 128'(exp));
  endtask

  initial begin
    rst = 1'b0;
    w_enable = 1'b0; w_addr = '0; w_data = '0;
    hw_we = 1'b0; hw_addr = '0; hw_data = '0;
    r_addr_a = '0; r_addr_b = '0;
    ro_data = 16'hBEEF;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Bank isolation
    step("b0w3", 1, 3, 'hA5, 0, 0, 0);
    step("sel2", 1, BSEL, 2, 0, 0, 0);
    step("b2w3", 1, 3, 'h5A, 0, 0, 0);
    rd_a("iso_b2", 3, 8'h5A);
    step("sel0", 1, BSEL, 0, 0, 0, 0);
    rd_a("iso_b0", 3, 8'hA5);

    // Write lands in the bank current at the edge; bank_q follows one cycle later
    step("b0w2", 1, 2, 'h11, 0, 0, 0);
    step("sel1", 1, BSEL, 1, 0, 0, 0);
    chk("sel1_bank", 128'(bank_q), 128'(1));
    rd_a("sel1_rd2", 2, 8'h00);
    step("sel0b", 1, BSEL, 0, 0, 0, 0);
    rd_a("b0_rd2", 2, 8'h11);

    // Invalid writes
    step("bsel7", 1, BSEL, 7, 0, 0, 0);
    chk("bsel7_err", 128'(err_pulse), 128'(1));
    step("idle1", 0, 0, 0, 0, 0, 0);
    step("ro_wr", 1, ROB, 'h33, 0, 0, 0);
    step("a40_wr", 1, 40, 'h44, 0, 0, 0);
    step("hw_bank", 0, 0, 0, 1, 5, 'h66);
    step("hw_bsel", 0, 0, 0, 1, BSEL, 1);
    step("idle2", 0, 0, 0, 0, 0, 0);

    // Trigger pulses
    step("trig3", 1, TRG, 'h03, 0, 0, 0);
    chk("trig3_val", 128'(trig_pulse), 128'(8'h03));
    step("trig3_clr", 0, 0, 0, 0, 0, 0);
    chk("trig3_zero", 128'(trig_pulse), 128'(0));
    step("trig1", 1, TRG, 'h01, 0, 0, 0);
    step("trig2", 1, TRG, 'h02, 0, 0, 0);
    chk("trig2_val", 128'(trig_pulse), 128'(8'h02));
    step("trig_end", 0, 0, 0, 0, 0, 0);

    // Port collision and independent simultaneous writes
    step("coll20", 1, 20, 'h10, 1, 20, 'h20);
    rd_a("coll_rd20", 20, 8'h20);
    chk("coll_err", 128'(err_pulse), 128'(1));
    step("dual", 1, 21, 'h77, 1, 22, 'h88);
    step("idle3", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with a trigger pending
    step("pre_rst_sel", 1, BSEL, 3, 0, 0, 0);
    step("pre_rst_trg", 1, TRG, 'h55, 1, 30, 'h9C);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    rd_a("rst_ro", ROB + 1, ro_data[15:8]);
    w_enable = 1'b1; w_addr = 6'd20; w_data = 8'h77;
    @(posedge clk);
    #1;
    check_all("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    step("first_wr", 1, 20, 'h77, 0, 0, 0);
    rd_a("first_rd", 20, 8'h77);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit swe, hwe;
      int sa, sd, ha, hd;
      if ($urandom_range(0, 7) == 0) ro_data = 16'($urandom);
      swe = ($urandom_range(0, 3) != 0);
      sa  = int'($urandom_range(0, 47));
      sd  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) sa = BSEL;
      if (sa == BSEL) sd = int'($urandom_range(0, 5));
      hwe = ($urandom_range(0, 2) == 0);
      ha  = int'($urandom_range(14, 34));
      if ($urandom_range(0, 3) == 0) ha = sa;
      hd  = int'($urandom_range(0, 255));
      step("rnd", swe, sa, sd, hwe, ha, hd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
